// File: rtl/dmem_port_arbiter.sv
// Data memory port arbiter: shares one memory port between FU Mem loads and LSQ store drain.
// Checks alignment/range/opcode, bounds store priority, and tracks two-cycle load responses.
module dmem_port_arbiter #(
    parameter int MEM_BYTES  = 2048,
    parameter int TAG_W      = 7,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_func3,
    input  logic [TAG_W-1:0] ld_tag,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic             st_half,
    input  logic             flush,
    output logic             mem_issued,
    output logic [6:0]       mem_opcode,
    output logic [2:0]       mem_func3,
    output logic [31:0]      mem_addr,
    output logic             mem_store_wb,
    output logic [31:0]      mem_st_addr,
    output logic [31:0]      mem_st_data,
    output logic             mem_st_half,
    input  logic             mem_valid,
    input  logic [31:0]      mem_data,
    output logic             resp_valid,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_data,
    output logic             resp_fault,
    output logic             st_fault,
    output logic             proto_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [32:0] MEM_END = 33'(MEM_BYTES);

    typedef struct packed {
        logic             v;
        logic             kill;
        logic             fault;
        logic [TAG_W-1:0] tag;
    } pipe_t;

    pipe_t s0, s1, s0_nx, s1_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic [1:0] quiet;
    logic proto_q;

    logic starve_max, st_grant, ld_grant;
    logic ld_bad, st_bad;
    logic [2:0] ld_size, st_size;
    logic [32:0] ld_end, st_end;

    always_comb begin
        ld_size = (ld_func3 == F3_LW) ? 3'd4 : 3'd1;
        ld_end  = {1'b0, ld_addr} + {30'd0, ld_size};
        ld_bad  = 1'b0;
        if (ld_func3 != F3_LW && ld_func3 != F3_LBU) ld_bad = 1'b1;
        if (ld_func3 == F3_LW && ld_addr[1:0] != 2'b00) ld_bad = 1'b1;
        if (ld_end > MEM_END) ld_bad = 1'b1;
    end

    always_comb begin
        st_size = st_half ? 3'd2 : 3'd4;
        st_end  = {1'b0, st_addr} + {30'd0, st_size};
        st_bad  = st_half ? st_addr[0] : (st_addr[1:0] != 2'b00);
        if (st_end > MEM_END) st_bad = 1'b1;
    end

    // Store normally wins; a waiting load breaks through once the store streak hits the limit.
    assign starve_max = (starve_cnt == STARVE_LIM);
    assign st_grant   = st_valid && !(ld_valid && starve_max);
    assign ld_grant   = ld_valid && !st_grant && !flush;
    assign ld_ready   = ld_grant;
    assign st_ready   = st_grant;

    always_comb begin
        starve_nx = starve_cnt;
        if (ld_valid && st_grant)
            starve_nx = starve_max ? starve_cnt : starve_cnt + SW'(1);
        else if (ld_grant || !ld_valid)
            starve_nx = '0;
    end

    assign mem_issued   = ld_grant && !ld_bad;
    assign mem_opcode   = mem_issued ? OP_LOAD : 7'd0;
    assign mem_func3    = mem_issued ? ld_func3 : 3'd0;
    assign mem_addr     = mem_issued ? ld_addr : 32'd0;
    assign mem_store_wb = st_grant && !st_bad;
    assign mem_st_addr  = mem_store_wb ? st_addr : 32'd0;
    assign mem_st_data  = mem_store_wb ? st_data : 32'd0;
    assign mem_st_half  = mem_store_wb && st_half;
    assign st_fault     = st_grant && st_bad;

    always_comb begin
        s0_nx       = '0;
        s0_nx.v     = ld_grant;
        s0_nx.fault = ld_bad;
        s0_nx.tag   = ld_tag;
        s1_nx       = s0;
        s1_nx.kill  = s0.kill || (flush && s0.v);
    end

    // Flush also squashes the entry leaving stage 1 in the same cycle.
    assign resp_valid = s1.v && !s1.kill && !flush;
    assign resp_tag   = resp_valid ? s1.tag : '0;
    assign resp_fault = resp_valid && s1.fault;
    assign resp_data  = (resp_valid && !s1.fault) ? mem_data : 32'd0;
    assign proto_err  = proto_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0         <= '0;
            s1         <= '0;
            starve_cnt <= '0;
            proto_q    <= 1'b0;
            quiet      <= 2'd2;
        end else begin
            s0         <= s0_nx;
            s1         <= s1_nx;
            starve_cnt <= starve_nx;
            if (quiet != 2'd0)
                quiet <= quiet - 2'd1;
            else if (mem_valid != (s1.v && !s1.fault))
                proto_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a two-cycle byte memory model.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_func3;
    logic [6:0]  ld_tag;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic        st_half, flush;
    logic        mem_issued;
    logic [6:0]  mem_opcode;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic        mem_store_wb;
    logic [31:0] mem_st_addr, mem_st_data;
    logic        mem_st_half;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = 32'd0;
    logic        resp_valid;
    logic [6:0]  resp_tag;
    logic [31:0] resp_data;
    logic        resp_fault, st_fault, proto_err;

    int checks = 0;
    int fails = 0;

    logic [7:0]  mem [0:2047];
    logic        mem_clr = 1'b1;
    logic        force_mv = 1'b0;
    logic        p_v = 1'b0;
    logic [31:0] p_addr = 32'd0;
    logic [2:0]  p_f3 = 3'd0;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_func3(ld_func3), .ld_tag(ld_tag),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_half(st_half), .flush(flush),
        .mem_issued(mem_issued), .mem_opcode(mem_opcode),
        .mem_func3(mem_func3), .mem_addr(mem_addr),
        .mem_store_wb(mem_store_wb), .mem_st_addr(mem_st_addr),
        .mem_st_data(mem_st_data), .mem_st_half(mem_st_half),
        .mem_valid(mem_valid), .mem_data(mem_data),
        .resp_valid(resp_valid), .resp_tag(resp_tag),
        .resp_data(resp_data), .resp_fault(resp_fault),
        .st_fault(st_fault), .proto_err(proto_err)
    );

    // Memory model: writes at the grant edge, read data valid two cycles after issue.
    always @(posedge clk) begin
        logic [10:0] a;
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        end
        if (mem_store_wb) begin
            a = mem_st_addr[10:0];
            mem[a]      = mem_st_data[7:0];
            mem[a + 1]  = mem_st_data[15:8];
            if (!mem_st_half) begin
                mem[a + 2] = mem_st_data[23:16];
                mem[a + 3] = mem_st_data[31:24];
            end
        end
        a = p_addr[10:0];
        mem_valid <= p_v || force_mv;
        if (!p_v)
            mem_data <= 32'd0;
        else if (p_f3 == 3'b010)
            mem_data <= {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
        else
            mem_data <= {24'd0, mem[a]};
        p_v    <= mem_issued;
        p_addr <= mem_addr;
        p_f3   <= mem_func3;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_valid = 0; ld_addr = 0; ld_func3 = 0; ld_tag = 0;
        st_valid = 0; st_addr = 0; st_data = 0; st_half = 0;
        flush = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f3, input logic [6:0] t);
        ld_valid = 1; ld_addr = a; ld_func3 = f3; ld_tag = t;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic h);
        st_valid = 1; st_addr = a; st_data = d; st_half = h;
    endtask

    initial begin
        idle();
        reset = 1;
        cyc(); cyc();
        mem_clr = 0;
        reset = 0;
        #2;
        chk("idle_resp_valid", 32'(resp_valid), 0);
        chk("idle_ld_ready", 32'(ld_ready), 0);
        chk("idle_st_ready", 32'(st_ready), 0);
        chk("idle_mem_issued", 32'(mem_issued), 0);
        chk("idle_store_wb", 32'(mem_store_wb), 0);
        chk("idle_proto", 32'(proto_err), 0);
        cyc(); cyc(); cyc();

        // sw then lw at 0x10
        store(32'h10, 32'hDEADBEEF, 0);
        #2;
        chk("sw_ready", 32'(st_ready), 1);
        chk("sw_wb", 32'(mem_store_wb), 1);
        chk("sw_fault", 32'(st_fault), 0);
        chk("sw_st_data", mem_st_data, 32'hDEADBEEF);
        cyc(); idle();
        load(32'h10, 3'b010, 7'd5);
        #2;
        chk("lw_ready", 32'(ld_ready), 1);
        chk("lw_issued", 32'(mem_issued), 1);
        chk("lw_opcode", 32'(mem_opcode), 32'h03);
        chk("lw_func3", 32'(mem_func3), 2);
        cyc(); idle(); #2;
        chk("lw_t1_resp", 32'(resp_valid), 0);
        cyc(); #2;
        chk("lw_t2_resp", 32'(resp_valid), 1);
        chk("lw_t2_tag", 32'(resp_tag), 5);
        chk("lw_t2_data", resp_data, 32'hDEADBEEF);
        chk("lw_t2_fault", 32'(resp_fault), 0);

        // starvation: S S S S L repeating
        cyc();
        load(32'h20, 3'b010, 7'd9);
        for (int i = 0; i < 10; i++) begin
            store(32'h20, 32'(i), 0);
            #2;
            chk($sformatf("starve_st_%0d", i), 32'(st_ready), 32'(i % 5 != 4));
            chk($sformatf("starve_ld_%0d", i), 32'(ld_ready), 32'(i % 5 == 4));
            cyc();
        end
        idle();
        cyc(); cyc();

        // faulted loads and in-range boundary loads
        load(32'h13, 3'b010, 7'd11); #2;
        chk("f_lw13_ready", 32'(ld_ready), 1);
        chk("f_lw13_issued", 32'(mem_issued), 0);
        cyc(); load(32'h0, 3'b000, 7'd12); #2;
        chk("f_f3_ready", 32'(ld_ready), 1);
        chk("f_f3_issued", 32'(mem_issued), 0);
        cyc(); load(32'h7FE, 3'b010, 7'd13); #2;
        chk("f_lw7fe_issued", 32'(mem_issued), 0);
        chk("f_r11_valid", 32'(resp_valid), 1);
        chk("f_r11_tag", 32'(resp_tag), 11);
        chk("f_r11_fault", 32'(resp_fault), 1);
        chk("f_r11_data", resp_data, 0);
        cyc(); load(32'h7FC, 3'b010, 7'd14); #2;
        chk("b_lw7fc_issued", 32'(mem_issued), 1);
        chk("f_r12_tag", 32'(resp_tag), 12);
        chk("f_r12_fault", 32'(resp_fault), 1);
        cyc(); load(32'h7FF, 3'b100, 7'd15); #2;
        chk("b_lbu7ff_issued", 32'(mem_issued), 1);
        chk("f_r13_tag", 32'(resp_tag), 13);
        chk("f_r13_fault", 32'(resp_fault), 1);
        chk("f_r13_data", resp_data, 0);
        cyc(); idle(); #2;
        chk("b_r14_tag", 32'(resp_tag), 14);
        chk("b_r14_fault", 32'(resp_fault), 0);
        cyc(); #2;
        chk("b_r15_valid", 32'(resp_valid), 1);
        chk("b_r15_fault", 32'(resp_fault), 0);
        cyc();

        // store faults
        store(32'h7FE, 32'h1234A55A, 1); #2;
        chk("sh7fe_wb", 32'(mem_store_wb), 1);
        chk("sh7fe_half", 32'(mem_st_half), 1);
        chk("sh7fe_fault", 32'(st_fault), 0);
        cyc(); store(32'h7FF, 32'h0000FFFF, 1); #2;
        chk("sh7ff_ready", 32'(st_ready), 1);
        chk("sh7ff_fault", 32'(st_fault), 1);
        chk("sh7ff_wb", 32'(mem_store_wb), 0);
        cyc(); store(32'h800, 32'hFFFFFFFF, 0); #2;
        chk("sw800_fault", 32'(st_fault), 1);
        chk("sw800_wb", 32'(mem_store_wb), 0);
        cyc(); store(32'h2, 32'hFFFFFFFF, 0); #2;
        chk("sw2_fault", 32'(st_fault), 1);
        cyc(); idle(); load(32'h7FF, 3'b100, 7'd20); #2;
        chk("st_fault_clear", 32'(st_fault), 0);
        cyc(); idle(); cyc(); #2;
        chk("lbu7ff_tag", 32'(resp_tag), 20);
        chk("lbu7ff_data", resp_data, 32'hA5);
        cyc();

        // flush squashes tags 1 and 2, tag 3 survives
        load(32'h10, 3'b010, 7'd1); #2;
        chk("fl_t1_ready", 32'(ld_ready), 1);
        cyc(); load(32'h14, 3'b010, 7'd2); #2;
        chk("fl_t2_ready", 32'(ld_ready), 1);
        cyc(); load(32'h10, 3'b010, 7'd3); flush = 1; #2;
        chk("fl_blocked", 32'(ld_ready), 0);
        chk("fl_no_resp1", 32'(resp_valid), 0);
        cyc(); flush = 0; #2;
        chk("fl_t3_ready", 32'(ld_ready), 1);
        chk("fl_no_resp2", 32'(resp_valid), 0);
        cyc(); idle(); #2;
        chk("fl_gap", 32'(resp_valid), 0);
        cyc(); #2;
        chk("fl_t3_valid", 32'(resp_valid), 1);
        chk("fl_t3_tag", 32'(resp_tag), 3);
        chk("fl_t3_data", resp_data, 32'hDEADBEEF);
        cyc(); #2;
        chk("fl_proto", 32'(proto_err), 0);

        // spurious mem_valid
        force_mv = 1;
        cyc(); force_mv = 0; #2;
        chk("pe_before", 32'(proto_err), 0);
        cyc(); #2;
        chk("pe_set", 32'(proto_err), 1);
        cyc(); cyc(); #2;
        chk("pe_sticky", 32'(proto_err), 1);
        reset = 1;
        cyc(); reset = 0; #2;
        chk("pe_reset", 32'(proto_err), 0);
        cyc(); cyc(); cyc();

        // reset with a load in flight
        load(32'h10, 3'b010, 7'd7); #2;
        chk("rst_ld_ready", 32'(ld_ready), 1);
        cyc(); idle(); reset = 1;
        cyc(); reset = 0; #2;
        chk("rst_no_resp1", 32'(resp_valid), 0);
        cyc(); #2;
        chk("rst_no_resp2", 32'(resp_valid), 0);
        cyc(); cyc(); #2;
        chk("rst_proto", 32'(proto_err), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
